// File: rtl/maze_pkg.sv
// maze_pkg: grid geometry, wall code, default game constants and game-flow states
package maze_pkg;
   localparam int GRID_W = 18;
   localparam int GRID_H = 11;
   localparam int NUM_CELLS = GRID_W * GRID_H;
   localparam logic [7:0] WALL_CODE = 8'd255;
   localparam logic [7:0] DEF_START_CELL = 8'd181;
   localparam logic [7:0] DEF_GOAL_CELL = 8'd16;
   localparam logic [2:0] DEF_LIVES = 3'd3;
   typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CRASHED, S_WON, S_OVER} state_t;
endpackage

// File: rtl/maze_position_tracker_if.sv
// maze_position_tracker_if: move-request inputs and game-flow outputs of the position tracker
interface maze_position_tracker_if;
   logic CTRLbtn;
   logic [7:0] next_count;
   logic [7:0] checkpoint_spot;
   logic [7:0] count;
   logic [7:0] last_valid;
   logic [7:0] begin_spot;
   logic game_pause;
   logic [2:0] lives;
   logic [15:0] steps;
   logic crash_pulse;
   logic win;
   logic over;
   modport master (
      output CTRLbtn, next_count, checkpoint_spot,
      input count, last_valid, begin_spot, game_pause, lives, steps, crash_pulse, win, over
   );
   modport slave (
      input CTRLbtn, next_count, checkpoint_spot,
      output count, last_valid, begin_spot, game_pause, lives, steps, crash_pulse, win, over
   );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q;
   always_ff @(posedge CLK)
      count_q <= clr_i ? '0 : (inc_i && count_q != '1) ? count_q + WIDTH'(1) : count_q;
   assign count_o = count_q;
endmodule

// File: rtl/maze_position_tracker.sv
// maze_position_tracker: commits player moves, tracks lives/checkpoint/steps and runs the
// idle/play/crash/won/over game flow; every output is registered.
module maze_position_tracker #(
   parameter logic [7:0] START_CELL = maze_pkg::DEF_START_CELL,
   parameter logic [7:0] GOAL_CELL  = maze_pkg::DEF_GOAL_CELL,
   parameter logic [2:0] LIVES      = maze_pkg::DEF_LIVES,
   parameter int         NUM_CELLS  = maze_pkg::NUM_CELLS
) (
   input logic CLK,
   input logic RESET,
   maze_position_tracker_if.slave bus
);
   import maze_pkg::*;
   state_t state_q, state_d;
   logic [7:0] count_q, count_d, last_q, last_d, begin_q, begin_d;
   logic [2:0] lives_q, lives_d;
   logic crash_q, crash_d, pause_q, win_q, over_q, step;
   // Any code outside the grid, including the 255 wall marker, is a crash.
   wire wall = int'(bus.next_count) >= NUM_CELLS;
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      last_d  = last_q;
      begin_d = begin_q;
      lives_d = lives_q;
      crash_d = 1'b0;
      step    = 1'b0;
      case (state_q)
         S_IDLE: state_d = bus.CTRLbtn ? S_PLAY : S_IDLE;
         S_PLAY:
            if (wall) begin
               count_d = WALL_CODE;
               crash_d = 1'b1;
               lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
               state_d = (lives_q <= 3'd1) ? S_OVER : S_CRASHED;
            end else if (bus.next_count != count_q) begin
               count_d = bus.next_count;
               last_d  = bus.next_count;
               step    = 1'b1;
               begin_d = (bus.checkpoint_spot != WALL_CODE && bus.next_count == bus.checkpoint_spot)
                         ? bus.next_count : begin_q;
               state_d = (bus.next_count == GOAL_CELL) ? S_WON : S_PLAY;
            end
         S_CRASHED:
            if (!wall) begin
               count_d = bus.next_count;
               last_d  = bus.next_count;
               state_d = S_PLAY;
            end
         default: ;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         count_q <= START_CELL;
         last_q  <= START_CELL;
         begin_q <= START_CELL;
         lives_q <= LIVES;
         crash_q <= 1'b0;
         pause_q <= 1'b0;
         win_q   <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         last_q  <= last_d;
         begin_q <= begin_d;
         lives_q <= lives_d;
         crash_q <= crash_d;
         pause_q <= state_d == S_PLAY || state_d == S_CRASHED;
         win_q   <= state_d == S_WON;
         over_q  <= state_d == S_OVER;
      end
   end
   sat_counter #(.WIDTH(16)) u_steps (
      .CLK    (CLK),
      .clr_i  (!RESET),
      .inc_i  (step),
      .count_o(bus.steps)
   );
   assign bus.count       = count_q;
   assign bus.last_valid  = last_q;
   assign bus.begin_spot  = begin_q;
   assign bus.game_pause  = pause_q;
   assign bus.lives       = lives_q;
   assign bus.crash_pulse = crash_q;
   assign bus.win         = win_q;
   assign bus.over        = over_q;
endmodule
